sp_dist_ram_256x8_async_rd: RTL and testbench
=============================================

Name:
sp_dist_ram_256x8_async_rd

Overview:
- Single-port 256-word x 8-bit RAM, mapped to distributed (LUT) RAM on Xilinx 7-series.
- Writes are synchronous to clk_in; reads are asynchronous (combinational from address_in).
- Used as a small scratch/lookup store inside CLB-level datapaths.
- Array is built from four 64x8 banks selected by address_in[7:6].

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 8, address width in bits; depth = 2**ADDR_WIDTH = 256.
- BANK_ADDR_WIDTH, 6, address bits per bank; 64 words per bank, 4 banks.

Ports:
- clk_in  input  1  write clock, rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- write_en  input  1  write enable, sampled on rising clk_in.
- address_in  input  8  read/write address.
- data_in  input  8  write data.
- data_out  output  8  asynchronous read data.

Behaviour:
- One clock (clk_in). Reset rst_n_in is asynchronous and active-low.
- Power-up contents: all 256 words = 8'h00, set by initialisation, not by reset.
- Write: on rising clk_in with rst_n_in=1 and write_en=1, mem[address_in] <= data_in. No write when write_en=0.
- Read is combinational: data_out = mem[address_in] whenever rst_n_in=1. There is no read latency.
- Address change: data_out follows in the same cycle, combinationally.
- Read-during-write, same address: before the edge, data_out shows old data. From the write edge onward it shows new data (write-first, visible right after the edge).
- Reset asserted (rst_n_in=0):
  - data_out forced to 8'h00 immediately, independent of clk_in.
  - All writes are inhibited.
  - Memory contents are retained. This keeps LUTRAM inference; no array clear.
- Reset deassertion: data_out returns to mem[address_in] immediately. The first write is possible at the next rising edge with rst_n_in=1.
- Reset mid-write: rst_n_in falling before the edge blocks the write. The location keeps its old value.
- Address wrap: address_in is 8 bits covering 0..255 fully. There are no out-of-range addresses.
- Bank selection:
  - bank = address_in[7:6]; offset = address_in[5:0].
  - Only the selected bank's write enable asserts.
  - data_out is a 4:1 mux of the bank outputs by address_in[7:6].
- Back-to-back writes to different addresses on consecutive cycles are all committed. Repeated writes to the same address: the last one wins.
- X handling: no X on data_out for any defined address after power-up.

Decomposition:
- Shared package sp_dist_ram_pkg holds:
  - constants DATA_WIDTH=8, ADDR_WIDTH=8, BANK_ADDR_WIDTH=6, NUM_BANKS=4;
  - typedefs data_t (logic [7:0]), addr_t (logic [7:0]), bank_sel_t (logic [1:0]).
- One sub-module, dist_ram_bank_64x8:
  - 64x8 LUTRAM with synchronous write and asynchronous read;
  - ports clk_in, we, addr[5:0], din[7:0], dout[7:0];
  - instantiated 4 times by the top.
- The top holds the bank decode, the output mux and reset gating.

Test Plan:
1. Power-up read: rst_n_in=1, write_en=0, sweep address_in 0..255 -> data_out=8'h00 at every address.
2. Write sweep:
   - Stimulus: write_en=1; each cycle address_in=A, data_in=D (random), for A=1..100; then write_en=0 and re-read 1..100.
   - Required: data_out equals D written at A. During the write sweep, data_out=D from the write edge until address changes.
3. Bank boundaries:
   - Stimulus: write 8'hA5@63, 8'h5A@64, 8'h3C@127, 8'hC3@128, 8'hFF@255, 8'h11@0.
   - Required: read-back returns exactly those values. Neighbouring addresses stay unchanged.
4. Read-during-write:
   - Stimulus: mem[10]=8'h22; address_in=10, data_in=8'h77, write_en=1.
   - Required: data_out=8'h22 before the edge, 8'h77 right after it.
5. Async reset:
   - Stimulus: after writing 8'h99@20, hold address_in=20 and pulse rst_n_in low mid-cycle with write_en=1, data_in=8'h44 across an edge.
   - Required: data_out=8'h00 immediately while low. On release data_out=8'h99 (write blocked, contents retained).
6. write_en=0 with data_in toggling at address 5 over 10 cycles -> mem[5] unchanged.

Source files
------------

// File: rtl/sp_dist_ram_pkg.sv
// Shared constants, types and address-split helpers for the 256x8
// distributed RAM and its 64x8 banks.
package sp_dist_ram_pkg;

   localparam int DATA_WIDTH      = 8;
   localparam int ADDR_WIDTH      = 8;
   localparam int BANK_ADDR_WIDTH = 6;
   localparam int NUM_BANKS       = 4;
   localparam int BANK_SEL_WIDTH  = ADDR_WIDTH - BANK_ADDR_WIDTH;
   localparam int BANK_DEPTH      = 2 ** BANK_ADDR_WIDTH;

   typedef logic [DATA_WIDTH-1:0]      data_t;
   typedef logic [ADDR_WIDTH-1:0]      addr_t;
   typedef logic [BANK_SEL_WIDTH-1:0]  bank_sel_t;
   typedef logic [BANK_ADDR_WIDTH-1:0] offset_t;

   // Upper address bits pick one of the four banks.
   function automatic bank_sel_t bank_of(input addr_t addr);
      return bank_sel_t'(addr >> BANK_ADDR_WIDTH);
   endfunction

   // Lower address bits address a word inside the selected bank.
   function automatic offset_t offset_of(input addr_t addr);
      return offset_t'(addr);
   endfunction

endpackage : sp_dist_ram_pkg

// File: rtl/sp_dist_ram_256x8_async_rd_bank.sv
// 64x8 LUT RAM bank: synchronous write on rising clk_in, combinational read.
// The array starts at all zeros through its declaration initialiser, so the
// contents are defined from configuration without needing any reset path.
module dist_ram_bank_64x8
   import sp_dist_ram_pkg::*;
(
   input  logic                       clk_in,
   input  logic                       we,
   input  logic [BANK_ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0]      din,
   output logic [DATA_WIDTH-1:0]      dout
);

   // Storage array; no reset so the tools keep it in LUT RAM.
   data_t mem_q [BANK_DEPTH] = '{default: '0};

   // Commit the write word at the rising edge when this bank is enabled.
   always_ff @(posedge clk_in) begin
      if (we) begin
         mem_q[addr] <= din;
      end
   end

   // Asynchronous read: a freshly written word shows up right after its edge.
   always_comb begin
      dout = mem_q[addr];
   end

endmodule : dist_ram_bank_64x8

// File: rtl/sp_dist_ram_256x8_async_rd.sv
// 256x8 single-port distributed RAM built from four 64x8 banks.
// The top decodes the bank from address_in[7:6], gates writes and the read
// data with the asynchronous active-low reset, and muxes the bank outputs.
module sp_dist_ram_256x8_async_rd
   import sp_dist_ram_pkg::*;
(
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] address_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);

   bank_sel_t            bank_sel;
   offset_t              bank_offset;
   logic [NUM_BANKS-1:0] bank_we;
   data_t                bank_dout [NUM_BANKS];
   data_t                mux_dout;
   logic                 write_ok;

   // Split the address into bank select and in-bank offset; writes are only
   // allowed while reset is released, so a reset falling before an edge
   // cancels that edge's write.
   always_comb begin
      bank_sel    = bank_of(address_in);
      bank_offset = offset_of(address_in);
      write_ok    = write_en & rst_n_in;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         // Only the addressed bank sees an active write enable.
         assign bank_we[gi] = write_ok & (bank_sel == bank_sel_t'(gi));

         dist_ram_bank_64x8 u_bank (
            .clk_in (clk_in),
            .we     (bank_we[gi]),
            .addr   (bank_offset),
            .din    (data_in),
            .dout   (bank_dout[gi])
         );
      end
   endgenerate

   // 4:1 read mux, forced to zero combinationally while reset is held low.
   always_comb begin
      mux_dout = bank_dout[bank_sel];
      data_out = rst_n_in ? mux_dout : '0;
   end

endmodule : sp_dist_ram_256x8_async_rd

// File: tb/tb_sp_dist_ram_256x8_async_rd.sv
// Self-checking bench for the 256x8 asynchronous-read distributed RAM.
// Expected values are pushed to a scoreboard queue when stimulus is driven
// and popped when the DUT output is sampled.
module tb_sp_dist_ram_256x8_async_rd;

   logic       clk_in;
   logic       rst_n_in;
   logic       write_en;
   logic [7:0] address_in;
   logic [7:0] data_in;
   logic [7:0] data_out;

   logic [7:0] model_mem [256];
   logic [7:0] exp_q [$];
   logic [7:0] exp_v;
   int         checks;
   int         errors;

   sp_dist_ram_256x8_async_rd dut (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .write_en   (write_en),
      .address_in (address_in),
      .data_in    (data_in),
      .data_out   (data_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Stimulus-only helper: one committed write, model updated after the edge.
   task automatic write_word(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk_in);
      address_in = a;
      data_in    = d;
      write_en   = 1'b1;
      @(posedge clk_in);
      #1;
      write_en     = 1'b0;
      model_mem[a] = d;
   endtask

   task automatic test_reset();
      rst_n_in   = 1'b0;
      write_en   = 1'b0;
      address_in = 8'd0;
      data_in    = 8'h00;
      exp_q.push_back(8'h00);
      #3;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
         errors++;
         $display("FAIL reset_out: got %02h expected %02h", data_out, exp_v);
      end
      $display("reset: data_out=%02h", data_out);
      @(negedge clk_in);
      rst_n_in = 1'b1;
   endtask

   task automatic test_powerup();
      int bad;
      bad = 0;
      for (int a = 0; a < 256; a++) begin
         address_in = 8'(a);
         exp_q.push_back(8'h00);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (data_out !== exp_v) begin
            errors++;
            bad++;
            $display("FAIL powerup_read[%0d]: got %02h expected %02h", a, data_out, exp_v);
         end
      end
      $display("powerup: swept 256 addresses, %0d bad", bad);
   endtask

   task automatic test_write_sweep();
      logic [7:0] d;
      for (int a = 1; a <= 100; a++) begin
         d = 8'($urandom_range(0, 255));
         @(negedge clk_in);
         address_in = 8'(a);
         data_in    = d;
         write_en   = 1'b1;
         exp_q.push_back(model_mem[a]);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (data_out !== exp_v) begin
            errors++;
            $display("FAIL sweep_pre[%0d]: got %02h expected %02h", a, data_out, exp_v);
         end
         exp_q.push_back(d);
         @(posedge clk_in);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (data_out !== exp_v) begin
            errors++;
            $display("FAIL sweep_post[%0d]: got %02h expected %02h", a, data_out, exp_v);
         end
         model_mem[a] = d;
         $display("sweep write a=%0d d=%02h out=%02h", a, d, data_out);
      end
      @(negedge clk_in);
      write_en = 1'b0;
      for (int a = 1; a <= 100; a++) begin
         address_in = 8'(a);
         exp_q.push_back(model_mem[a]);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (data_out !== exp_v) begin
            errors++;
            $display("FAIL sweep_reread[%0d]: got %02h expected %02h", a, data_out, exp_v);
         end
      end
      $display("sweep: reread addresses 1..100");
   endtask

   task automatic test_bank_boundaries();
      logic [7:0] addrs [8];
      addrs = '{8'd63, 8'd64, 8'd127, 8'd128, 8'd255, 8'd0, 8'd200, 8'd201};
      write_word(8'd63,  8'hA5);
      write_word(8'd64,  8'h5A);
      write_word(8'd127, 8'h3C);
      write_word(8'd128, 8'hC3);
      write_word(8'd255, 8'hFF);
      write_word(8'd0,   8'h11);
      // Back-to-back writes to the same address: the last one wins.
      write_word(8'd200, 8'h12);
      write_word(8'd200, 8'h34);
      @(negedge clk_in);
      for (int i = 0; i < 8; i++) begin
         for (int off = -1; off <= 1; off++) begin
            address_in = addrs[i] + 8'(off);
            exp_q.push_back(model_mem[address_in]);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (data_out !== exp_v) begin
               errors++;
               $display("FAIL bank_read[%0d]: got %02h expected %02h", address_in, data_out, exp_v);
            end
            $display("bank read a=%0d out=%02h exp=%02h", address_in, data_out, exp_v);
         end
      end
   endtask

   task automatic test_read_during_write();
      write_word(8'd10, 8'h22);
      @(negedge clk_in);
      address_in = 8'd10;
      data_in    = 8'h77;
      write_en   = 1'b1;
      exp_q.push_back(8'h22);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
         errors++;
         $display("FAIL rdw_before: got %02h expected %02h", data_out, exp_v);
      end
      exp_q.push_back(8'h77);
      @(posedge clk_in);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
         errors++;
         $display("FAIL rdw_after: got %02h expected %02h", data_out, exp_v);
      end
      write_en      = 1'b0;
      model_mem[10] = 8'h77;
      $display("rdw: addr 10 now %02h", data_out);
   endtask

   task automatic test_async_reset();
      write_word(8'd20, 8'h99);
      @(negedge clk_in);
      address_in = 8'd20;
      data_in    = 8'h44;
      write_en   = 1'b1;
      #2;
      rst_n_in = 1'b0;
      exp_q.push_back(8'h00);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
         errors++;
         $display("FAIL areset_immediate: got %02h expected %02h", data_out, exp_v);
      end
      exp_q.push_back(8'h00);
      @(posedge clk_in);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
         errors++;
         $display("FAIL areset_held: got %02h expected %02h", data_out, exp_v);
      end
      write_en = 1'b0;
      #1;
      rst_n_in = 1'b1;
      exp_q.push_back(model_mem[20]);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin
         errors++;
         $display("FAIL areset_release: got %02h expected %02h", data_out, exp_v);
      end
      $display("async reset: addr 20 after release %02h", data_out);
   endtask

   task automatic test_we_low();
      write_word(8'd5, 8'h5E);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_in);
         address_in = 8'd5;
         write_en   = 1'b0;
         data_in    = 8'($urandom_range(0, 255));
         exp_q.push_back(model_mem[5]);
         @(posedge clk_in);
         #1;
         exp_v = exp_q.pop_front();
         checks++;
         if (data_out !== exp_v) begin
            errors++;
            $display("FAIL we_low[%0d]: got %02h expected %02h", c, data_out, exp_v);
         end
         $display("we_low cycle %0d din=%02h out=%02h", c, data_in, data_out);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
      test_reset();
      test_powerup();
      test_write_sweep();
      test_bank_boundaries();
      test_read_during_write();
      test_async_reset();
      test_we_low();
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sp_dist_ram_256x8_async_rd
